dm_pipelined: RTL and testbench

Parametrised, pipelined data memory for the CPU datapath. It serves one load or store request per cycle through a valid/ready handshake and returns in-order responses after a configurable latency. It supports word, halfword and byte accesses (signed and unsigned loads) over a configurable base address and depth. It reports faults with a cause code, and zeroes its array with a post-reset clear sequence.

---
 rtl/dm_pipelined.sv | 176 +++++++++++++++++
 tb/tb_dm_pipelined.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_pipelined.sv
// Pipelined data memory: one load/store per cycle, in-order responses after LATENCY cycles.
// Word/half/byte access, fault reporting with cause code, and a post-reset zeroing sequence.
module dm_pipelined #(
  parameter int unsigned DEPTH          = 4096,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned LATENCY        = 2,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  resp_fault_code,
  output logic [31:0] resp_pc,
  output logic        init_done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [2:0] MODE_W  = 3'd1;
  localparam logic [2:0] MODE_H  = 3'd2;
  localparam logic [2:0] MODE_HU = 3'd3;
  localparam logic [2:0] MODE_B  = 3'd4;
  localparam logic [2:0] MODE_BU = 3'd5;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  clr_cnt;
  logic           clr_we;
  logic [31:0]    mem [DEPTH];

  logic           accept;
  logic [32:0]    offset;
  logic           in_range;
  logic [AW-1:0]  idx;
  logic           misaligned;
  logic [1:0]     code_c;
  logic [31:0]    word_c;
  logic [15:0]    half_c;
  logic [7:0]     byte_c;
  logic [31:0]    load_c;
  logic [31:0]    rdata_c;
  logic [31:0]    merged_c;
  logic           store_en;

  logic           pipe_valid [LATENCY];
  logic [31:0]    pipe_rdata [LATENCY];
  logic [1:0]     pipe_code  [LATENCY];
  logic [31:0]    pipe_pc    [LATENCY];

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (state == S_CLEAR && clr_cnt == AW'(DEPTH - 1)) state_next = S_RUN;
  end

  // FSM: outputs
  always_comb begin
    clr_we    = 1'b0;
    req_ready = 1'b0;
    case (state)
      S_CLEAR: clr_we    = 1'b1;
      S_RUN:   req_ready = !reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      if (clr_we) clr_cnt <= clr_cnt + AW'(1);
      init_done <= (state_next == S_RUN);
    end
  end

  assign accept   = req_valid && req_ready;
  // 33-bit subtraction: addresses below the base borrow into bit 32 and land out of range
  assign offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign in_range = (offset < SPAN);
  assign idx      = offset[AW+1:2];
  assign word_c   = mem[idx];

  always_comb begin
    misaligned = 1'b0;
    case (req_mode)
      MODE_W:          misaligned = |req_addr[1:0];
      MODE_H, MODE_HU: misaligned = req_addr[0];
      default:         misaligned = 1'b0;
    endcase
    if (req_mode > MODE_BU) code_c = 2'b11;
    else if (!in_range)     code_c = 2'b10;
    else if (misaligned)    code_c = 2'b01;
    else                    code_c = 2'b00;
  end

  // Load extraction and store read-modify-write, both from the addressed word
  always_comb begin
    half_c   = word_c[{req_addr[1], 4'b0000} +: 16];
    byte_c   = word_c[{req_addr[1:0], 3'b000} +: 8];
    load_c   = '0;
    merged_c = word_c;
    case (req_mode)
      MODE_W: begin
        load_c   = word_c;
        merged_c = req_wdata;
      end
      MODE_H: begin
        load_c = {{16{half_c[15]}}, half_c};
        merged_c[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      end
      MODE_HU: load_c = {16'h0000, half_c};
      MODE_B: begin
        load_c = {{24{byte_c[7]}}, byte_c};
        merged_c[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end
      MODE_BU: load_c = {24'h000000, byte_c};
      default: load_c = '0;
    endcase
    rdata_c  = (req_we || code_c != 2'b00) ? 32'h0 : load_c;
    store_en = accept && req_we && (code_c == 2'b00) &&
               (req_mode == MODE_W || req_mode == MODE_H || req_mode == MODE_B);
  end

  // Single write port shared by the clear sequence and committed stores
  always_ff @(posedge clk) begin
    if (clr_we)        mem[clr_cnt] <= '0;
    else if (store_en) mem[idx]     <= merged_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_rdata[i] <= '0;
        pipe_code[i]  <= '0;
        pipe_pc[i]    <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_rdata[0] <= accept ? rdata_c : 32'h0;
      pipe_code[0]  <= accept ? code_c  : 2'b00;
      pipe_pc[0]    <= accept ? req_pc  : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
        pipe_code[i]  <= pipe_code[i-1];
        pipe_pc[i]    <= pipe_pc[i-1];
      end
    end
  end

  assign resp_valid      = pipe_valid[LATENCY-1];
  assign resp_rdata      = pipe_rdata[LATENCY-1];
  assign resp_fault_code = pipe_code[LATENCY-1];
  assign resp_fault      = |pipe_code[LATENCY-1];
  assign resp_pc         = pipe_pc[LATENCY-1];

endmodule

// File: tb/tb_dm_pipelined.sv
// Bench for dm_pipelined: directed table, hand sequences and random traffic against a
// byte-lane memory model with per-response due-cycle checking.
module tb_dm_pipelined;

  localparam int unsigned DEPTH   = 16;
  localparam logic [31:0] BASE    = 32'h0000_0100;
  localparam int unsigned LATENCY = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_fault, init_done;
  logic [31:0] resp_rdata, resp_pc;
  logic [1:0]  resp_fault_code;

  dm_pipelined #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_fault_code(resp_fault_code), .resp_pc(resp_pc), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic [1:0]  code;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] off;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [1:0]  code;
  } vec_t;

  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  bit          mon_en = 1'b0;
  exp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  vec_t        tab [26];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: byte-lane arithmetic over a word array
  function automatic void model_access(input logic we, input logic [2:0] mode,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic [1:0] code);
    longint unsigned a   = 64'(addr);
    longint unsigned lo  = 64'(BASE);
    longint unsigned hi  = 64'(BASE) + 64'(4 * DEPTH);
    int unsigned     size, w, sh;
    logic [31:0]     mask, v, top;
    rd   = 32'h0;
    size = (mode == 3'd1) ? 4 : (mode == 3'd2 || mode == 3'd3) ? 2 : 1;
    if (mode > 3'd5)             code = 2'b11;
    else if (a < lo || a >= hi)  code = 2'b10;
    else if (addr % size != 0)   code = 2'b01;
    else                         code = 2'b00;
    if (code != 2'b00 || mode == 3'd0) return;
    w    = 32'((a - lo) / 4);
    sh   = (addr % 4) * 8;
    mask = (size == 4) ? 32'hFFFF_FFFF : (((32'd1 << (size * 8)) - 32'd1) << sh);
    if (we) begin
      if (mode == 3'd1 || mode == 3'd2 || mode == 3'd4)
        mem_m[w] = (mem_m[w] & ~mask) | ((wdata << sh) & mask);
    end else begin
      v = (mem_m[w] & mask) >> sh;
      if ((mode == 3'd2 || mode == 3'd4)) begin
        top = 32'd1 << (size * 8 - 1);
        v   = (v ^ top) - top;
      end
      rd = v;
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
  endtask

  task automatic issue(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       input logic use_tab, input logic [31:0] t_rd, input logic [1:0] t_code);
    logic [31:0] mrd;
    logic [1:0]  mcode;
    int          waits = 0;
    exp_t        e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_mode = mode;
    req_addr = addr; req_wdata = wdata; req_pc = pc;
    while (!req_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_access(we, mode, addr, wdata, mrd, mcode);
    e.due  = cyc + LATENCY;
    e.rd   = use_tab ? t_rd : mrd;
    e.code = use_tab ? t_code : mcode;
    e.pc   = pc;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Releases reset and measures how long the clear keeps the port closed
  task automatic release_and_count();
    int n = 0;
    @(negedge clk);
    reset = 1'b0;
    chk("init_done_low_at_release", 32'(init_done), 32'd0);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", 32'(n), 32'd16);
    chk("init_done_after_clear", 32'(init_done), 32'd1);
  endtask

  // Response monitor: every accepted request answers exactly at its due cycle, in order
  exp_t mon_e;
  logic mon_exp_v;
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      mon_exp_v = (q.size() != 0) && (q[0].due == cyc);
      chk("resp_valid", 32'(resp_valid), 32'(mon_exp_v));
      if (mon_exp_v) begin
        mon_e = q.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rd);
        chk("resp_fault_code", 32'(resp_fault_code), 32'(mon_e.code));
        chk("resp_fault", 32'(resp_fault), 32'(mon_e.code != 2'b00));
        chk("resp_pc", resp_pc, mon_e.pc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0]  mode;
    logic [31:0] addr;
    int          r;

    tab[0]  = '{1'b1, 3'd1, 32'h0000_0000, 32'h8765_4321, 32'h0000_0000, 2'b00};
    tab[1]  = '{1'b1, 3'd4, 32'h0000_0001, 32'h0000_00AA, 32'h0000_0000, 2'b00};
    tab[2]  = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'h8765_AA21, 2'b00};
    tab[3]  = '{1'b0, 3'd4, 32'h0000_0001, 32'h0,         32'hFFFF_FFAA, 2'b00};
    tab[4]  = '{1'b0, 3'd5, 32'h0000_0001, 32'h0,         32'h0000_00AA, 2'b00};
    tab[5]  = '{1'b0, 3'd2, 32'h0000_0002, 32'h0,         32'hFFFF_8765, 2'b00};
    tab[6]  = '{1'b0, 3'd3, 32'h0000_0002, 32'h0,         32'h0000_8765, 2'b00};
    tab[7]  = '{1'b0, 3'd1, 32'h0000_0002, 32'h0,         32'h0000_0000, 2'b01};
    tab[8]  = '{1'b1, 3'd2, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_0000, 2'b01};
    tab[9]  = '{1'b0, 3'd1, 32'h0000_0000, 32'h0,         32'h8765_AA21, 2'b00};
    tab[10] = '{1'b1, 3'd2, 32'h0000_0040, 32'h0000_1234, 32'h0000_0000, 2'b10};
    tab[11] = '{1'b0, 3'd6, 32'h0000_0003, 32'h0,         32'h0000_0000, 2'b11};
    tab[12] = '{1'b1, 3'd7, 32'hFFFF_FFFC, 32'h1,         32'h0000_0000, 2'b11};
    tab[13] = '{1'b0, 3'd1, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 2'b10};
    tab[14] = '{1'b0, 3'd1, 32'h0000_0042, 32'h0,         32'h0000_0000, 2'b10};
    tab[15] = '{1'b1, 3'd3, 32'h0000_0008, 32'h0000_5555, 32'h0000_0000, 2'b00};
    tab[16] = '{1'b0, 3'd1, 32'h0000_0008, 32'h0,         32'h0000_0000, 2'b00};
    tab[17] = '{1'b0, 3'd0, 32'h0000_0005, 32'h0,         32'h0000_0000, 2'b00};
    tab[18] = '{1'b0, 3'd0, 32'h0000_0040, 32'h0,         32'h0000_0000, 2'b10};
    tab[19] = '{1'b1, 3'd2, 32'h0000_0006, 32'h1234_BEEF, 32'h0000_0000, 2'b00};
    tab[20] = '{1'b1, 3'd4, 32'h0000_0007, 32'h0000_0011, 32'h0000_0000, 2'b00};
    tab[21] = '{1'b0, 3'd1, 32'h0000_0004, 32'h0,         32'h11EF_0000, 2'b00};
    tab[22] = '{1'b0, 3'd2, 32'h0000_0006, 32'h0,         32'h0000_11EF, 2'b00};
    tab[23] = '{1'b1, 3'd1, 32'h0000_003C, 32'hCAFE_F00D, 32'h0000_0000, 2'b00};
    tab[24] = '{1'b0, 3'd4, 32'h0000_003F, 32'h0,         32'hFFFF_FFCA, 2'b00};
    tab[25] = '{1'b0, 3'd5, 32'h0000_003C, 32'h0,         32'h0000_000D, 2'b00};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_mode = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    model_clear();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_resp_fault_code", 32'(resp_fault_code), 32'd0);
    chk("rst_resp_pc", resp_pc, 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    mon_en = 1'b1;
    release_and_count();

    // First load after clear reads zero at the configured latency
    issue(1'b0, 3'd1, BASE, 32'h0, 32'h0000_0010, 1'b1, 32'h0, 2'b00);
    idle();
    repeat (LATENCY + 1) @(negedge clk);

    // Directed table, issued back to back
    for (int i = 0; i < 26; i++)
      issue(tab[i].we, tab[i].mode, BASE + tab[i].off, tab[i].wdata,
            32'h4000_0000 + 32'(i * 4), 1'b1, tab[i].rd, tab[i].code);
    idle();
    repeat (LATENCY + 1) @(negedge clk);

    // Alternating store/load pairs: each load sees the store one cycle earlier
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 3'd1, BASE + 32'(i * 4), 32'h1111_0000 + 32'(i), 32'h5000_0000 + 32'(i * 8),
            1'b1, 32'h0, 2'b00);
      issue(1'b0, 3'd1, BASE + 32'(i * 4), 32'h0, 32'h5000_0004 + 32'(i * 8),
            1'b1, 32'h1111_0000 + 32'(i), 2'b00);
    end
    idle();
    repeat (LATENCY + 1) @(negedge clk);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 3'(6 + $urandom_range(0, 1));
      else                            mode = 3'($urandom_range(0, 5));
      r = int'($urandom_range(0, 19));
      if (r == 0)      addr = BASE - 32'($urandom_range(1, 8));
      else if (r == 1) addr = BASE + 32'h40 + 32'($urandom_range(0, 8));
      else             addr = BASE + 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), mode, addr, $urandom, 32'h8000_0000 + 32'(i * 4),
            1'b0, 32'h0, 2'b00);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    repeat (LATENCY + 1) @(negedge clk);

    // Reset with two requests in flight: both are dropped and the clear restarts
    issue(1'b1, 3'd1, BASE + 32'h8, 32'hDEAD_BEEF, 32'h6000_0000, 1'b0, 32'h0, 2'b00);
    issue(1'b0, 3'd1, BASE + 32'h8, 32'h0, 32'h6000_0004, 1'b0, 32'h0, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    q.delete();
    model_clear();
    repeat (2) begin
      @(negedge clk);
      chk("inflight_resp_valid_in_reset", 32'(resp_valid), 32'd0);
      chk("inflight_ready_in_reset", 32'(req_ready), 32'd0);
    end
    release_and_count();
    issue(1'b0, 3'd1, BASE + 32'h8, 32'h0, 32'h6000_0008, 1'b1, 32'h0, 2'b00);
    idle();
    repeat (LATENCY + 2) @(negedge clk);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
